// File: rtl/irom_pkg.sv
// Shared types for the instruction-memory port arbiter.
// Holds state and owner encodings plus the word-address width helper.
package irom_pkg;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_L
    } owner_e;

    function automatic int addr_width(input int space);
        return $clog2(space);
    endfunction

endpackage

// File: rtl/irom_port_arbiter_if.sv
// Bus bundle between requesters, arbiter and instruction RAM.
// Ports: fetch (f_*), loader (l_*), RAM side (mem_*); slave = arbiter view.
interface irom_port_arbiter_if
    import irom_pkg::*;
#(
    parameter int IROM_SPACE = 4096
);
    localparam int AW = addr_width(IROM_SPACE);

    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;

    logic          l_req;
    logic [3:0]    l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;

    logic          mem_cs;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/irom_starve_cnt.sv
// Saturating count of consecutive cycles a request was refused.
// Ports: clk, rstn, req, gnt in; sat out (count reached MAX_WAIT).
module irom_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic req,
    input  logic gnt,
    output logic sat
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (!sat) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/irom_port_arbiter.sv
// Shares a single-port sync-read instruction RAM between fetch and loader.
// Ports: clk, rstn, boot_done/boot_busy, bus (slave). Option: IROM_BOOT_LOCK_EN.
module irom_port_arbiter
    import irom_pkg::*;
#(
    parameter int IROM_SPACE = 4096,
    parameter int MAX_WAIT   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 boot_done,
    output logic                 boot_busy,
    irom_port_arbiter_if.slave   bus
);
    localparam int AW = addr_width(IROM_SPACE);

    state_e state;
    owner_e owner;
    logic   in_boot;
    logic   l_sat;
    logic   f_gnt;
    logic   l_gnt;

`ifdef IROM_BOOT_LOCK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_BOOT;
            boot_busy <= 1'b1;
        end else if (state == ST_BOOT && boot_done) begin
            state     <= ST_RUN;
            boot_busy <= 1'b0;
        end
    end
`else
    logic boot_unused;
    assign state       = ST_RUN;
    assign boot_busy   = 1'b0;
    assign boot_unused = boot_done;
`endif

    assign in_boot = (state == ST_BOOT);

    irom_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk (clk),
        .rstn(rstn),
        .req (bus.l_req),
        .gnt (l_gnt),
        .sat (l_sat)
    );

    // Grants are gated by rstn so nothing reaches the RAM during reset.
    always_comb begin
        l_gnt = 1'b0;
        f_gnt = 1'b0;
        if (rstn) begin
            if (in_boot) begin
                l_gnt = bus.l_req;
            end else begin
                l_gnt = bus.l_req & (~bus.f_req | l_sat);
                f_gnt = bus.f_req & ~l_gnt;
            end
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.mem_cs    = f_gnt | l_gnt;
    assign bus.mem_we    = l_gnt ? bus.l_we : 4'b0;
    assign bus.mem_addr  = f_gnt ? bus.f_addr[AW+1:2]
                                 : bus.l_addr[AW+1:2];
    assign bus.mem_wdata = bus.l_wdata;

    // Byte offset and bits above the RAM depth are dropped: addresses wrap.
    logic addr_unused;
    assign addr_unused = ^{bus.f_addr[31:AW+2], bus.f_addr[1:0],
                           bus.l_addr[31:AW+2], bus.l_addr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner <= OWN_NONE;
        end else begin
            unique case (1'b1)
                l_gnt:   owner <= OWN_L;
                f_gnt:   owner <= OWN_F;
                default: owner <= OWN_NONE;
            endcase
        end
    end

    assign bus.f_rvalid = (owner == OWN_F);
    assign bus.l_rvalid = (owner == OWN_L);
    assign bus.f_rdata  = bus.mem_rdata;
    assign bus.l_rdata  = bus.mem_rdata;

endmodule
